// File: rtl/uart_receive.sv
// ----------------------------------------------------------------------------
// uart_receive
//
// Serial-to-parallel UART receiver. It detects a start bit on an
// already-synchronous serial line and samples every bit in the middle of
// the bit period. It assembles the data bits LSB first, checks the stop bit,
// and presents the word through a valid/ready handshake.
//
// Parameters
//   d_width      data bits per frame (must match the transmitter)
//   clks_per_bit clock cycles per serial bit (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   rx         serial line, idle high: start(0), data LSB first, stop(1)
//   rx_ready   consumer accepts the held word when high together with rx_valid
//   rx_data    received word, stable while rx_valid is high
//   rx_valid   word available, held until accepted
//   rx_busy    high while a frame is in progress
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a good frame completes while a word is
//              still waiting to be accepted (the new word is dropped)
// ----------------------------------------------------------------------------
module uart_receive #(
    parameter int d_width      = 4,
    parameter int clks_per_bit = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int half    = (clks_per_bit - 1) / 2;
    localparam int half_m1 = (half > 0) ? half - 1 : 0;
    localparam int cnt_w   = $clog2(clks_per_bit) + 1;
    localparam int bit_w   = $clog2(d_width + 2);

    // The cycle counter counts down to zero; a sample happens on the cycle
    // where it reads zero, then it reloads for the next bit period.
    localparam logic [cnt_w-1:0] cnt_reload = cnt_w'(clks_per_bit - 1);
    localparam logic [cnt_w-1:0] cnt_half   = cnt_w'(half_m1);
    localparam logic [bit_w-1:0] last_bit   = bit_w'(d_width - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [bit_w-1:0]   bit_q, bit_d;
    logic [d_width-1:0] shift_q, shift_d;
    logic [d_width-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_busy_q, rx_busy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        // A held word is released the cycle after it is accepted.
        rx_valid_d  = rx_valid_q && !rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx) begin
                    bit_d = '0;
                    if (half == 0) begin
                        // Mid-start-bit is the detection cycle itself, and
                        // rx is already known to be low here.
                        state_d = DATA;
                        cnt_d   = cnt_reload;
                    end else begin
                        state_d = START;
                        cnt_d   = cnt_half;
                    end
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx) begin
                        state_d = IDLE;     // glitch, not a real start bit
                    end else begin
                        state_d = DATA;
                        cnt_d   = cnt_reload;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_w'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[bit_q] = rx;
                    cnt_d          = cnt_reload;
                    if (bit_q == last_bit) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + bit_w'(1);
                    end
                end else begin
                    cnt_d = cnt_q - cnt_w'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    bit_d   = '0;
                    if (rx) begin
                        // Acceptance in this same cycle frees the slot.
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_w'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receive.sv
// ----------------------------------------------------------------------------
// tb_uart_receive
//
// Exercises two receiver instances: one at one clock per bit and one at four
// clocks per bit. Frames are generated directly on the serial line. Inputs
// change on the falling edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_uart_receive;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx1, rdy1, rx4, rdy4;
    logic [3:0] data1, data4;
    logic       valid1, busy1, ferr1, ovr1;
    logic       valid4, busy4, ferr4, ovr4;

    int checks = 0;
    int errors = 0;

    uart_receive #(.d_width(4), .clks_per_bit(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_ready(rdy1),
        .rx_data(data1), .rx_valid(valid1), .rx_busy(busy1),
        .frame_err(ferr1), .overrun(ovr1)
    );

    uart_receive #(.d_width(4), .clks_per_bit(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4), .rx_ready(rdy4),
        .rx_data(data4), .rx_valid(valid4), .rx_busy(busy4),
        .frame_err(ferr4), .overrun(ovr4)
    );

    typedef struct {
        logic [3:0] data;
        logic       stop;
        logic       rdy_during;
        logic       rdy_stop;
        logic       exp_valid;
        logic [3:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame at one clock per bit. Returns with the line idle, at the
    // falling edge just after the stop-bit sample (T+6).
    task automatic send1(input logic [3:0] d, input logic stop,
                         input logic rdy_during, input logic rdy_stop,
                         output logic valid_at_stop);
        @(negedge clk); rx1 = 1'b0; rdy1 = rdy_during;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rx1 = d[i];
        end
        @(negedge clk);
        chk("busy_mid_frame", busy1, 1'b1);
        valid_at_stop = valid1;
        rx1 = stop; rdy1 = rdy_during | rdy_stop;
        @(negedge clk); rx1 = 1'b1; rdy1 = 1'b0;
    endtask

    initial begin
        logic pre_valid;
        logic seen;
        logic [3:0] frame4;

        //             data  stop dur stp  valid data  ferr ovr
        vecs[0] = '{4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0};
        vecs[1] = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0};
        vecs[2] = '{4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1};
        vecs[3] = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0};
        vecs[4] = '{4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0};
        vecs[5] = '{4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0};
        vecs[6] = '{4'hD, 1'b1, 1'b1, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0};
        vecs[7] = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 1'b0};

        rst_n = 1'b0; rx1 = 1'b1; rx4 = 1'b1; rdy1 = 1'b0; rdy4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_1", {data1, valid1, busy1, ferr1, ovr1}, 8'h00);
        chk("reset_outputs_4", {data4, valid4, busy4, ferr4, ovr4}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- clks_per_bit = 1, table-driven ----------------
        for (int i = 0; i < 8; i++) begin
            send1(vecs[i].data, vecs[i].stop, vecs[i].rdy_during, vecs[i].rdy_stop, pre_valid);
            $display("vec %0d: sent %h stop=%0b -> valid=%0b data=%h ferr=%0b ovr=%0b",
                     i, vecs[i].data, vecs[i].stop, valid1, data1, ferr1, ovr1);
            chk("vec_valid", valid1, vecs[i].exp_valid);
            chk("vec_data", data1, vecs[i].exp_data);
            chk("vec_frame_err", ferr1, vecs[i].exp_ferr);
            chk("vec_overrun", ovr1, vecs[i].exp_ovr);
            chk("vec_busy_after", busy1, 1'b0);
            @(negedge clk);
            chk("pulse_width", {ferr1, ovr1}, 2'b00);
            if (i == 0) begin
                chk("valid_not_before_T6", pre_valid, 1'b0);
                repeat (3) @(negedge clk);
                chk("valid_held", {valid1, data1}, {1'b1, 4'hA});
                rdy1 = 1'b1;
                @(negedge clk); rdy1 = 1'b0;
                chk("valid_cleared_after_accept", valid1, 1'b0);
                $display("accept: valid=%0b after rx_ready pulse", valid1);
            end
        end

        // ---------------- reset during data bit 2 of frame F ----------------
        @(negedge clk); rx1 = 1'b0;
        @(negedge clk); rx1 = 1'b1;
        @(negedge clk); rx1 = 1'b1;
        @(negedge clk); rx1 = 1'b1; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("midframe_reset_outputs", {data1, valid1, busy1, ferr1, ovr1}, 8'h00);
        repeat (8) @(negedge clk);
        chk("no_valid_after_reset", {valid1, ferr1, ovr1}, 3'b000);
        $display("midframe reset: valid=%0b data=%h", valid1, data1);
        send1(4'h9, 1'b1, 1'b0, 1'b0, pre_valid);
        $display("post-reset frame: valid=%0b data=%h", valid1, data1);
        chk("post_reset_frame", {valid1, data1, ferr1, ovr1}, {1'b1, 4'h9, 2'b00});

        // ---------------- clks_per_bit = 4, frame 6 ----------------
        frame4 = 4'h6;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 21) chk("cpb4_not_yet_valid", {valid4, busy4}, 2'b01);
            if (c == 22) chk("cpb4_valid_T22", {valid4, busy4, data4}, {2'b10, 4'h6});
            if (c < 4)       rx4 = 1'b0;
            else if (c < 20) rx4 = frame4[(c - 4) / 4];
            else             rx4 = 1'b1;
        end
        $display("cpb4 frame: valid=%0b data=%h", valid4, data4);
        chk("cpb4_flags", {ferr4, ovr4}, 2'b00);
        rdy4 = 1'b1;
        @(negedge clk); rdy4 = 1'b0;
        chk("cpb4_accept", valid4, 1'b0);

        // ---------------- clks_per_bit = 4, start glitch ----------------
        @(negedge clk); rx4 = 1'b0;
        @(negedge clk); rx4 = 1'b1;
        chk("glitch_busy_after_T", busy4, 1'b1);
        @(negedge clk);
        chk("glitch_false_start_idle", busy4, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            seen = seen | valid4 | ferr4 | ovr4 | busy4;
        end
        $display("glitch: any activity=%0b", seen);
        chk("glitch_no_flags", seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
